// File: rtl/gpio_multi_pkg.sv
// Shared definitions for the multi-port GPIO: register offsets within a port's
// eight-register window and the address split between port index and offset.
package gpio_multi_pkg;

    localparam int REG_OFF_W = 3;

    typedef enum logic [REG_OFF_W-1:0] {
        REG_DATA    = 3'd0,
        REG_DIR     = 3'd1,
        REG_SET     = 3'd2,
        REG_CLR     = 3'd3,
        REG_TGL     = 3'd4,
        REG_FLAGS   = 3'd5,
        REG_RISE_EN = 3'd6,
        REG_FALL_EN = 3'd7
    } reg_off_e;

    // Address width for a given port count: {port_idx, reg_off}.
    function automatic int addr_width(input int nports);
        return $clog2(nports) + REG_OFF_W;
    endfunction

endpackage

// File: rtl/gpio_multi_port.sv
// One GPIO port: output latch with atomic set/clear/toggle, direction, input
// synchroniser, edge detection into sticky W1C flags, and the port's read mux.
module gpio_multi_port
    import gpio_multi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  reg_off_e         reg_off,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    inout  wire  [WIDTH-1:0] pins,
    output logic             irq
);

    logic [WIDTH-1:0]                  r_out;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  r_flags;
    logic [WIDTH-1:0]                  r_rise_en;
    logic [WIDTH-1:0]                  r_fall_en;
    logic [WIDTH-1:0]                  r_prev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_flag_clr;
    logic [WIDTH-1:0] w_flags_next;
    logic [WIDTH-1:0] w_out_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign pins[i] = r_dir[i] ? r_out[i] : 1'bz;
    end

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_s & ~r_prev;
    assign w_fall  = ~w_s & r_prev;
    assign w_event = ((w_rise & r_rise_en) | (w_fall & r_fall_en)) & ~r_dir;

    // A new edge in the same cycle as a W1C keeps the flag set.
    assign w_flag_clr   = (wr_en && reg_off == REG_FLAGS) ? wr_data : '0;
    assign w_flags_next = (r_flags & ~w_flag_clr) | w_event;

    always_comb begin
        // NOTE: default first so every path assigns w_out_next; otherwise a latch is inferred.
        w_out_next = r_out;
        if (wr_en) begin
            case (reg_off)
                REG_DATA: w_out_next = wr_data;
                REG_SET:  w_out_next = r_out | wr_data;
                REG_CLR:  w_out_next = r_out & ~wr_data;
                REG_TGL:  w_out_next = r_out ^ wr_data;
                default:  w_out_next = r_out;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_flags   <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_prev    <= '0;
            r_sync    <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pins};
            r_prev  <= w_s;
            r_out   <= w_out_next;
            r_flags <= w_flags_next;
            if (wr_en && reg_off == REG_DIR)     r_dir     <= wr_data;
            if (wr_en && reg_off == REG_RISE_EN) r_rise_en <= wr_data;
            if (wr_en && reg_off == REG_FALL_EN) r_fall_en <= wr_data;
        end
    end

    assign irq = |r_flags;

    always_comb begin
        rd_data = '0;
        case (reg_off)
            REG_DATA:    rd_data = w_s;
            REG_DIR:     rd_data = r_dir;
            REG_FLAGS:   rd_data = r_flags;
            REG_RISE_EN: rd_data = r_rise_en;
            REG_FALL_EN: rd_data = r_fall_en;
            default:     rd_data = '0;
        endcase
    end

endmodule

// File: rtl/gpio_multi.sv
// Multi-port GPIO top: splits the address into port index and register offset,
// steers the write strobe to one port, muxes read data and combines interrupts.
module gpio_multi
    import gpio_multi_pkg::*;
#(
    parameter  int NPORTS      = 2,
    parameter  int WIDTH       = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int ADDR_W      = $clog2(NPORTS) + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    inout  wire  [NPORTS*WIDTH-1:0] pins,
    output logic [NPORTS-1:0]       irq_port,
    output logic                    irq
);

    // Port index kept at full address width so NPORTS=1 needs no zero-width slice.
    logic [ADDR_W-1:0] w_port_idx;
    reg_off_e          w_reg_off;
    logic [WIDTH-1:0]  w_port_rd [NPORTS];

    assign w_port_idx = addr >> REG_OFF_W;
    assign w_reg_off  = reg_off_e'(addr[REG_OFF_W-1:0]);

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        gpio_multi_port #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en && (w_port_idx == ADDR_W'(p))),
            .reg_off (w_reg_off),
            .wr_data (wr_data),
            .rd_data (w_port_rd[p]),
            .pins    (pins[p*WIDTH +: WIDTH]),
            .irq     (irq_port[p])
        );
    end

    // Indices at or beyond NPORTS match no port: reads give 0, writes go nowhere.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_port_idx == ADDR_W'(p)) rd_data = w_port_rd[p];
        end
    end

    assign irq = |irq_port;

endmodule
